input_load_controller: RTL and testbench
========================================

Name: input_load_controller

Overview:
- Sequences one matrix-load-and-feed transaction for the 4x4 systolic MAC array.
- Loads one A row and one B column per beat from the source into input_datapath, using a valid/ready handshake plus next_row/next_col advance pulses.
- Waits for load_done, then enables the array for the skewed feed window and a drain window, and reports completion.
- Sits between the top-level control and input_datapath / the PE array.

Parameters:
- DIM, 4, matrix dimension; beats per load (rows = cols = DIM).
- FEED_CYCLES, 2*DIM-1 (7), cycles array_en stays high (skewed 56-bit operand width / 8 bits).
- DRAIN_CYCLES, DIM (4), cycles after feed for the last partial sums to settle.
- TIMEOUT, 255, maximum WAIT_LOAD cycles before error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transaction; sampled in IDLE only.
- abort  in  1  synchronous cancel; returns to IDLE.
- src_valid  in  1  source has a 64-bit beat on data_in (passed through to the datapath).
- load_done  in  1  from input_datapath: all DIM rows and columns captured.
- dest_ready  out  1  to input_datapath: accept the current beat.
- next_row  out  1  1-cycle pulse advancing the datapath row counter.
- next_col  out  1  1-cycle pulse advancing the datapath column counter.
- array_en  out  1  PE array shift/accumulate enable.
- feed_idx  out  3  current feed cycle, 0..FEED_CYCLES-1; 0 outside FEED.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse at transaction end.
- timeout_err  out  1  sticky; set on WAIT_LOAD timeout, cleared on the next accepted start or on reset.

Behaviour:
- States: IDLE, LOAD, ADVANCE, WAIT_LOAD, FEED, DRAIN, DONE. All outputs are registered Moore outputs.
- Reset: state=IDLE. All outputs 0. beat_cnt, feed/drain counters and timeout counter = 0.
- IDLE:
  - start=1 → LOAD next cycle; beat_cnt=0; timeout_err cleared.
  - start while busy is ignored.
- LOAD:
  - dest_ready=1.
  - A beat is accepted at a rising edge where src_valid & dest_ready = 1; beat_cnt increments and the state moves to ADVANCE.
  - With src_valid=0, stay in LOAD indefinitely; no timeout applies here.
- ADVANCE:
  - dest_ready=0; next_row=next_col=1 for exactly one cycle.
  - Next state is LOAD if beat_cnt<DIM, else WAIT_LOAD.
  - Minimum spacing is 2 cycles per beat; back-to-back acceptance is forbidden.
- WAIT_LOAD:
  - load_done sampled 1 → FEED.
  - Otherwise the timeout counter increments. At TIMEOUT cycles: timeout_err=1, go to DONE, and skip FEED/DRAIN.
- FEED:
  - array_en=1 for exactly FEED_CYCLES cycles.
  - feed_idx counts 0..FEED_CYCLES-1, then the state moves to DRAIN.
- DRAIN:
  - array_en=0 for DRAIN_CYCLES cycles, then DONE.
- DONE:
  - done=1 and busy=1 for one cycle, then IDLE.
  - A start asserted in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
- Latency, start sampled at edge 0 with src_valid held high and load_done already high:
  - LOAD cycles 1,3,5,7; ADVANCE cycles 2,4,6,8.
  - WAIT_LOAD cycle 9; FEED cycles 10-16; DRAIN cycles 17-20.
  - done=1 in cycle 21.
- abort:
  - Priority: reset > abort > all other transitions.
  - In any non-IDLE state, abort → IDLE next cycle with all pulse/enable outputs 0 and counters cleared.
  - done is not asserted on abort. timeout_err is retained.
- Reset mid-operation: identical to the reset values above on the next edge, from any state.
- Counter widths: beat_cnt holds $clog2(DIM+1) bits. Counters never wrap in legal operation; an exit at the terminal count is guaranteed.

Decomposition:
- Shared package systolic_pkg holds:
  - DIM, ELEM_W=8, and the derived FEED_CYCLES/DRAIN_CYCLES constants.
  - The ctrl_state_e enum (IDLE, LOAD, ADVANCE, WAIT_LOAD, FEED, DRAIN, DONE).
- One natural sub-module: cycle_counter, a loadable down-counter with a terminal-count flag. It is reused for the feed, drain and timeout counts.
- The FSM and the beat counter stay in the top module.

Test Plan:
- Nominal: reset 2 cycles; start pulse at cycle 0; src_valid=1 held; load_done=1 from cycle 9.
  → dest_ready high in cycles 1,3,5,7.
  → next_row/next_col pulses in cycles 2,4,6,8.
  → array_en high in cycles 10-16 with feed_idx 0..6.
  → done=1 only in cycle 21.
- Stalled source: src_valid low for 3 cycles before beat 2.
  → dest_ready stays 1 across the stall; no next_row pulse during the stall; exactly 4 pulses in total.
- Timeout: load_done held 0 after 4 beats.
  → after 255 WAIT_LOAD cycles, timeout_err=1 and done=1 next cycle; array_en never high.
  → A following start clears timeout_err.
- Abort: assert abort during FEED at feed_idx=3.
  → next cycle IDLE, array_en=0, busy=0, no done pulse.
  → A new start runs the full nominal sequence.
- Reset mid-LOAD after 2 beats → all outputs 0 next cycle; a restart requires 4 fresh beats.
- start held high continuously → exactly one transaction per IDLE entry; start is ignored while busy and in DONE.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and controller state encoding for the 4x4 systolic MAC array.
package systolic_pkg;

    localparam int unsigned DIM          = 4;
    localparam int unsigned ELEM_W       = 8;
    // Skewed operand span across the array, in bits; one element enters per feed cycle.
    localparam int unsigned SKEW_W       = (2 * DIM - 1) * ELEM_W;
    localparam int unsigned FEED_CYCLES  = SKEW_W / ELEM_W;
    localparam int unsigned DRAIN_CYCLES = DIM;
    localparam int unsigned TIMEOUT      = 255;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BEAT_W = $clog2(DIM + 1);
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADVANCE,
        WAIT_LOAD,
        FEED,
        DRAIN,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter with a terminal-count (zero) flag.
module cycle_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // Terminal count flag.
    always_comb begin
        zero_c = (count == '0);
    end

endmodule

// File: rtl/input_load_controller.sv
// Sequences one load-and-feed transaction for the 4x4 systolic MAC array.
module input_load_controller
    import systolic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             src_valid,
    input  logic             load_done,
    output logic             dest_ready,
    output logic             next_row,
    output logic             next_col,
    output logic             array_en,
    output logic [IDX_W-1:0] feed_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    ctrl_state_e       state;
    ctrl_state_e       state_next;
    logic [BEAT_W-1:0] beat_cnt;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero_c;

    logic beat_clr;
    logic beat_inc;
    logic timeout_set;
    logic timeout_clr;

    // Shared counter for the feed window, drain window and load timeout.
    cycle_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .zero_c   (cnt_zero_c)
    );

    // Next-state and counter control; abort overrides every non-idle transition.
    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = '0;
        beat_clr     = 1'b0;
        beat_inc     = 1'b0;
        timeout_set  = 1'b0;
        timeout_clr  = 1'b0;

        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            cnt_load   = 1'b1;
            beat_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next  = LOAD;
                        beat_clr    = 1'b1;
                        timeout_clr = 1'b1;
                    end
                end
                LOAD: begin
                    if (src_valid && dest_ready) begin
                        state_next = ADVANCE;
                        beat_inc   = 1'b1;
                    end
                end
                ADVANCE: begin
                    if (beat_cnt < BEAT_W'(DIM)) begin
                        state_next = LOAD;
                    end else begin
                        state_next   = WAIT_LOAD;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(TIMEOUT - 1);
                    end
                end
                WAIT_LOAD: begin
                    if (load_done) begin
                        state_next   = FEED;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(FEED_CYCLES - 1);
                    end else if (cnt_zero_c) begin
                        state_next  = DONE;
                        timeout_set = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                FEED: begin
                    if (cnt_zero_c) begin
                        state_next   = DRAIN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt_zero_c) begin
                        state_next = DONE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, beat counter and Moore outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            dest_ready  <= 1'b0;
            next_row    <= 1'b0;
            next_col    <= 1'b0;
            array_en    <= 1'b0;
            feed_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;

            if (beat_clr) begin
                beat_cnt <= '0;
            end else if (beat_inc) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end

            dest_ready <= (state_next == LOAD);
            next_row   <= (state_next == ADVANCE);
            next_col   <= (state_next == ADVANCE);
            array_en   <= (state_next == FEED);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);

            if (state_next != FEED) begin
                feed_idx <= '0;
            end else if (state == FEED) begin
                feed_idx <= feed_idx + IDX_W'(1);
            end else begin
                feed_idx <= '0;
            end

            if (timeout_set) begin
                timeout_err <= 1'b1;
            end else if (timeout_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_load_controller.sv
// Randomized and directed bench for input_load_controller against a transaction-level model.
module tb_input_load_controller;

    localparam int M_DIM     = 4;
    localparam int M_FEED    = 2 * M_DIM - 1;
    localparam int M_DRAIN   = M_DIM;
    localparam int M_TIMEOUT = 255;
    localparam int M_TAIL    = M_FEED + M_DRAIN + 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       src_valid;
    logic       load_done;
    logic       dest_ready;
    logic       next_row;
    logic       next_col;
    logic       array_en;
    logic [2:0] feed_idx;
    logic       busy;
    logic       done;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: transaction phase expressed as beats taken, advance pulse, wait length and
    // a countdown of remaining post-load cycles (feed + drain + done).
    bit m_busy, m_loading, m_adv, m_waiting, m_err;
    int m_beats, m_waited, m_tail;

    input_load_controller dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .src_valid   (src_valid),
        .load_done   (load_done),
        .dest_ready  (dest_ready),
        .next_row    (next_row),
        .next_col    (next_col),
        .array_en    (array_en),
        .feed_idx    (feed_idx),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input logic dr, input logic nr, input logic nc,
                                         input logic ae, input logic [2:0] fi,
                                         input logic b, input logic d, input logic te);
        return {22'd0, dr, nr, nc, ae, fi, b, d, te};
    endfunction

    function automatic void model_clear();
        m_busy = 0; m_loading = 0; m_adv = 0; m_waiting = 0;
        m_beats = 0; m_waited = 0; m_tail = 0;
    endfunction

    function automatic void model_update(input bit rst, input bit st, input bit ab,
                                         input bit v, input bit ld);
        if (rst) begin
            model_clear();
            m_err = 0;
        end else if (m_busy && ab) begin
            model_clear();
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_loading = 1; m_beats = 0; m_err = 0;
            end
        end else if (m_loading) begin
            if (v) begin
                m_beats++; m_loading = 0; m_adv = 1;
            end
        end else if (m_adv) begin
            m_adv = 0;
            if (m_beats < M_DIM) m_loading = 1;
            else begin
                m_waiting = 1; m_waited = 0;
            end
        end else if (m_waiting) begin
            m_waited++;
            if (ld) begin
                m_waiting = 0; m_tail = M_TAIL;
            end else if (m_waited == M_TIMEOUT) begin
                m_waiting = 0; m_err = 1; m_tail = 1;
            end
        end else if (m_tail > 0) begin
            m_tail--;
            if (m_tail == 0) m_busy = 0;
        end
    endfunction

    function automatic logic [31:0] model_outs();
        logic       ae;
        logic [2:0] fi;
        ae = (m_tail > M_DRAIN + 1);
        fi = ae ? 3'(M_TAIL - m_tail) : 3'd0;
        return pack(m_loading, m_adv, m_adv, ae, fi, m_busy, (m_tail == 1), m_err);
    endfunction

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic step(input bit rst, input bit st, input bit ab, input bit v, input bit ld);
        reset = rst; start = st; abort = ab; src_valid = v; load_done = ld;
        @(posedge clk);
        model_update(rst, st, ab, v, ld);
        #1;
        cyc++;
        check_eq("outs", pack(dest_ready, next_row, next_col, array_en, feed_idx,
                              busy, done, timeout_err), model_outs());
    endtask

    // Full nominal transaction from IDLE; outputs after step c belong to cycle c.
    task automatic run_nominal(input string tag);
        int done_at = -1;
        int ae_cnt  = 0;
        int nr_cnt  = 0;
        for (int c = 1; c <= 26; c++) begin
            step(0, (c == 1), 0, 1, 1);
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (array_en === 1'b1) ae_cnt++;
            if (next_row === 1'b1) nr_cnt++;
        end
        check_eq({tag, "_done_cycle"}, 32'(done_at), 32'd21);
        check_eq({tag, "_feed_cycles"}, 32'(ae_cnt), 32'(M_FEED));
        check_eq({tag, "_row_pulses"}, 32'(nr_cnt), 32'(M_DIM));
    endtask

    initial begin
        int  done_at;
        int  cnt;
        bit  found;
        bit  saw_err;
        bit  st, ab, rs, v, ld;

        m_err = 0;
        model_clear();

        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check_eq("reset_outs", pack(dest_ready, next_row, next_col, array_en, feed_idx,
                                    busy, done, timeout_err), 32'd0);
        step(0, 0, 0, 0, 0);

        // Nominal
        run_nominal("nom");

        // Stalled source before beat 2
        cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            step(0, (c == 1), 0, !(c >= 3 && c <= 5), 1);
            if (next_row === 1'b1) cnt++;
            if (c >= 3 && c <= 5) begin
                check_eq("stall_ready", 32'(dest_ready), 32'd1);
                check_eq("stall_no_pulse", 32'(next_row), 32'd0);
            end
        end
        check_eq("stall_row_pulses", 32'(cnt), 32'(M_DIM));

        // Timeout: load_done never arrives
        done_at = -1; cnt = 0; saw_err = 0;
        for (int c = 1; c <= 300; c++) begin
            step(0, (c == 1), 0, 1, 0);
            if (array_en === 1'b1) cnt++;
            if (done === 1'b1 && done_at < 0) begin
                done_at = c;
                saw_err = timeout_err;
            end
        end
        check_eq("to_done_cycle", 32'(done_at), 32'd264);
        check_eq("to_err_at_done", 32'(saw_err), 32'd1);
        check_eq("to_no_feed", 32'(cnt), 32'd0);
        check_eq("to_err_sticky", 32'(timeout_err), 32'd1);
        step(0, 1, 0, 1, 1);
        check_eq("to_err_cleared", 32'(timeout_err), 32'd0);
        for (int c = 0; c < 25; c++) step(0, 0, 0, 1, 1);

        // Abort in FEED at feed_idx 3
        found = 0;
        step(0, 1, 0, 1, 1);
        for (int c = 0; c < 40 && !found; c++) begin
            if (array_en === 1'b1 && feed_idx === 3'd3) found = 1;
            else step(0, 0, 0, 1, 1);
        end
        check_eq("abort_reach_feed3", 32'(found), 32'd1);
        step(0, 0, 1, 1, 1);
        check_eq("abort_idle", pack(dest_ready, next_row, next_col, array_en, feed_idx,
                                    busy, done, timeout_err), 32'd0);
        step(0, 0, 0, 1, 1);
        check_eq("abort_no_done", 32'(done), 32'd0);
        run_nominal("post_abort");

        // Reset mid-LOAD after two beats
        for (int c = 1; c <= 4; c++) step(0, (c == 1), 0, 1, 1);
        step(1, 0, 0, 1, 1);
        check_eq("midreset_outs", pack(dest_ready, next_row, next_col, array_en, feed_idx,
                                       busy, done, timeout_err), 32'd0);
        run_nominal("post_reset");

        // start held high: one transaction per IDLE entry
        cnt = 0;
        for (int c = 1; c <= 65; c++) begin
            step(0, 1, 0, 1, 1);
            if (done === 1'b1) cnt++;
        end
        check_eq("held_start_dones", 32'(cnt), 32'd3);
        step(1, 0, 0, 0, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rs = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 39) == 0);
            v  = 1'($urandom_range(0, 1));
            ld = ($urandom_range(0, 3) == 0);
            step(rs, st, ab, v, ld);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
